// File: rtl/eth_rx_filter.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_filter
// Description : Receive-side frame filter.
//               Each frame is either forwarded whole or discarded whole. The
//               decision uses the destination MAC (local, broadcast or
//               promiscuous) and the EtherType (two accepted values).
//               Saturating counters track passed and dropped frames.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_filter #(
   parameter int          DATA_WIDTH  = 8,
   parameter int          KEEP_ENABLE = (DATA_WIDTH > 8),
   parameter int          KEEP_WIDTH  = DATA_WIDTH / 8,
   parameter logic [15:0] ETH_TYPE_0  = 16'h0800,
   parameter logic [15:0] ETH_TYPE_1  = 16'h0806,
   parameter int          CNT_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  s_eth_hdr_valid,
   output logic                  s_eth_hdr_ready,
   input  logic [47:0]           s_eth_dest_mac,
   input  logic [47:0]           s_eth_src_mac,
   input  logic [15:0]           s_eth_type,
   input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep,
   input  logic                  s_eth_payload_axis_tvalid,
   output logic                  s_eth_payload_axis_tready,
   input  logic                  s_eth_payload_axis_tlast,
   input  logic                  s_eth_payload_axis_tuser,

   output logic                  m_eth_hdr_valid,
   input  logic                  m_eth_hdr_ready,
   output logic [47:0]           m_eth_dest_mac,
   output logic [47:0]           m_eth_src_mac,
   output logic [15:0]           m_eth_type,
   output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep,
   output logic                  m_eth_payload_axis_tvalid,
   input  logic                  m_eth_payload_axis_tready,
   output logic                  m_eth_payload_axis_tlast,
   output logic                  m_eth_payload_axis_tuser,

   input  logic [47:0]           local_mac,
   input  logic                  promiscuous,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  pass_count,
   output logic [CNT_WIDTH-1:0]  drop_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   localparam logic [47:0]          C_BCAST   = 48'hFFFF_FFFF_FFFF;
   localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                  state_q;
   logic                    hdr_valid_q;
   logic [47:0]             dest_q;
   logic [47:0]             src_q;
   logic [15:0]             type_q;
   logic [DATA_WIDTH-1:0]   tdata_q;
   logic                    tvalid_q;
   logic                    tlast_q;
   logic                    tuser_q;
   logic [CNT_WIDTH-1:0]    pass_cnt_q, pass_cnt_d;
   logic [CNT_WIDTH-1:0]    drop_cnt_q, drop_cnt_d;

   logic                    hdr_ready;
   logic                    pay_ready;
   logic                    hdr_fire;
   logic                    beat_fire;
   logic                    pass_load;
   logic                    out_fire;
   logic                    mac_ok;
   logic                    type_ok;
   logic                    frame_ok;

   // Handshake decode, filter decision and saturating counter next-state
   always_comb begin
      // A new header waits until the FSM is idle and the previous header left
      hdr_ready = (state_q == ST_IDLE) && !hdr_valid_q;
      case (state_q)
         ST_PASS: pay_ready = !tvalid_q || m_eth_payload_axis_tready;
         ST_DROP: pay_ready = 1'b1;
         default: pay_ready = 1'b0;
      endcase
      hdr_fire  = s_eth_hdr_valid && hdr_ready;
      beat_fire = s_eth_payload_axis_tvalid && pay_ready;
      pass_load = beat_fire && (state_q == ST_PASS);
      out_fire  = tvalid_q && m_eth_payload_axis_tready;

      mac_ok    = promiscuous || (s_eth_dest_mac == local_mac) || (s_eth_dest_mac == C_BCAST);
      type_ok   = (s_eth_type == ETH_TYPE_0) || (s_eth_type == ETH_TYPE_1);
      frame_ok  = mac_ok && type_ok;

      pass_cnt_d = pass_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (hdr_fire && frame_ok && (pass_cnt_q != C_CNT_MAX)) begin
         pass_cnt_d = pass_cnt_q + C_CNT_ONE;
      end
      if (hdr_fire && !frame_ok && (drop_cnt_q != C_CNT_MAX)) begin
         drop_cnt_d = drop_cnt_q + C_CNT_ONE;
      end
   end

   // Frame FSM with header, payload and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         hdr_valid_q <= 1'b0;
         dest_q      <= '0;
         src_q       <= '0;
         type_q      <= '0;
         tdata_q     <= '0;
         tvalid_q    <= 1'b0;
         tlast_q     <= 1'b0;
         tuser_q     <= 1'b0;
         pass_cnt_q  <= '0;
         drop_cnt_q  <= '0;
      end else begin
         pass_cnt_q <= pass_cnt_d;
         drop_cnt_q <= drop_cnt_d;

         // Header output drains independently of the payload
         if (hdr_valid_q && m_eth_hdr_ready) begin
            hdr_valid_q <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               if (hdr_fire) begin
                  if (frame_ok) begin
                     dest_q      <= s_eth_dest_mac;
                     src_q       <= s_eth_src_mac;
                     type_q      <= s_eth_type;
                     hdr_valid_q <= 1'b1;
                     state_q     <= ST_PASS;
                  end else begin
                     state_q     <= ST_DROP;
                  end
               end
            end
            ST_PASS, ST_DROP: begin
               if (beat_fire && s_eth_payload_axis_tlast) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase

         // One-deep payload output register
         if (pass_load) begin
            tdata_q  <= s_eth_payload_axis_tdata;
            tlast_q  <= s_eth_payload_axis_tlast;
            tuser_q  <= s_eth_payload_axis_tuser;
            tvalid_q <= 1'b1;
         end else if (out_fire) begin
            tvalid_q <= 1'b0;
         end
      end
   end

   generate
      if (KEEP_ENABLE != 0) begin : g_keep
         logic [KEEP_WIDTH-1:0] tkeep_q;

         // tkeep travels with the payload register
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               tkeep_q <= '0;
            end else if (pass_load) begin
               tkeep_q <= s_eth_payload_axis_tkeep;
            end
         end

         assign m_eth_payload_axis_tkeep = tkeep_q;
      end else begin : g_no_keep
         logic unused_tkeep;
         assign unused_tkeep             = ^s_eth_payload_axis_tkeep;
         assign m_eth_payload_axis_tkeep = {KEEP_WIDTH{1'b1}};
      end
   endgenerate

   assign s_eth_hdr_ready           = hdr_ready;
   assign s_eth_payload_axis_tready = pay_ready;
   assign m_eth_hdr_valid           = hdr_valid_q;
   assign m_eth_dest_mac            = dest_q;
   assign m_eth_src_mac             = src_q;
   assign m_eth_type                = type_q;
   assign m_eth_payload_axis_tdata  = tdata_q;
   assign m_eth_payload_axis_tvalid = tvalid_q;
   assign m_eth_payload_axis_tlast  = tlast_q;
   assign m_eth_payload_axis_tuser  = tuser_q;
   assign busy                      = (state_q != ST_IDLE);
   assign pass_count                = pass_cnt_q;
   assign drop_count                = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_rx_filter
// Description : Scoreboard bench for eth_rx_filter. A second instance with
//               2-bit counters shares all inputs to exercise saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_rx_filter;

   localparam int          DW      = 8;
   localparam int          KW      = 1;
   localparam int          TIMEOUT = 2000;
   localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] MAC_A   = 48'h02_00_00_00_00_01;
   localparam logic [47:0] MAC_B   = 48'h02_00_00_00_00_02;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          s_eth_hdr_valid, s_eth_hdr_ready;
   logic [47:0]   s_eth_dest_mac, s_eth_src_mac;
   logic [15:0]   s_eth_type;
   logic [DW-1:0] s_tdata;
   logic [KW-1:0] s_tkeep;
   logic          s_tvalid, s_tready, s_tlast, s_tuser;
   logic          m_eth_hdr_valid, m_eth_hdr_ready;
   logic [47:0]   m_eth_dest_mac, m_eth_src_mac;
   logic [15:0]   m_eth_type;
   logic [DW-1:0] m_tdata;
   logic [KW-1:0] m_tkeep;
   logic          m_tvalid, m_tready, m_tlast, m_tuser;
   logic [47:0]   local_mac;
   logic          promiscuous;
   logic          busy;
   logic [15:0]   pass_count, drop_count;

   // outputs of the narrow-counter instance
   logic          x_hdr_ready, x_tready, x_hdr_valid, x_tvalid, x_tlast, x_tuser, x_busy;
   logic [47:0]   x_dest, x_src;
   logic [15:0]   x_type;
   logic [DW-1:0] x_tdata;
   logic [KW-1:0] x_tkeep;
   logic [1:0]    x_pass, x_drop;

   eth_rx_filter #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .s_eth_hdr_valid(s_eth_hdr_valid), .s_eth_hdr_ready(s_eth_hdr_ready),
      .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
      .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tkeep(s_tkeep),
      .s_eth_payload_axis_tvalid(s_tvalid), .s_eth_payload_axis_tready(s_tready),
      .s_eth_payload_axis_tlast(s_tlast), .s_eth_payload_axis_tuser(s_tuser),
      .m_eth_hdr_valid(m_eth_hdr_valid), .m_eth_hdr_ready(m_eth_hdr_ready),
      .m_eth_dest_mac(m_eth_dest_mac), .m_eth_src_mac(m_eth_src_mac), .m_eth_type(m_eth_type),
      .m_eth_payload_axis_tdata(m_tdata), .m_eth_payload_axis_tkeep(m_tkeep),
      .m_eth_payload_axis_tvalid(m_tvalid), .m_eth_payload_axis_tready(m_tready),
      .m_eth_payload_axis_tlast(m_tlast), .m_eth_payload_axis_tuser(m_tuser),
      .local_mac(local_mac), .promiscuous(promiscuous), .busy(busy),
      .pass_count(pass_count), .drop_count(drop_count)
   );

   eth_rx_filter #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) dut_sat (
      .clk(clk), .rst(rst),
      .s_eth_hdr_valid(s_eth_hdr_valid), .s_eth_hdr_ready(x_hdr_ready),
      .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
      .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tkeep(s_tkeep),
      .s_eth_payload_axis_tvalid(s_tvalid), .s_eth_payload_axis_tready(x_tready),
      .s_eth_payload_axis_tlast(s_tlast), .s_eth_payload_axis_tuser(s_tuser),
      .m_eth_hdr_valid(x_hdr_valid), .m_eth_hdr_ready(m_eth_hdr_ready),
      .m_eth_dest_mac(x_dest), .m_eth_src_mac(x_src), .m_eth_type(x_type),
      .m_eth_payload_axis_tdata(x_tdata), .m_eth_payload_axis_tkeep(x_tkeep),
      .m_eth_payload_axis_tvalid(x_tvalid), .m_eth_payload_axis_tready(m_tready),
      .m_eth_payload_axis_tlast(x_tlast), .m_eth_payload_axis_tuser(x_tuser),
      .local_mac(local_mac), .promiscuous(promiscuous), .busy(x_busy),
      .pass_count(x_pass), .drop_count(x_drop)
   );

   typedef struct {
      logic [47:0] dest;
      logic [47:0] src;
      logic [15:0] typ;
   } hdr_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      logic          user;
   } beat_t;

   hdr_t        exp_hdr_q[$];
   beat_t       exp_beat_q[$];
   int unsigned mdl_pass, mdl_drop;
   int          checks, errors;
   int          pay_mode;   // 0: always ready, 1: toggle, 2: random
   int          hdr_mode;   // 0: always ready, 1: random
   int          hdr_hold;   // cycles to hold m_eth_hdr_ready low

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
   endtask

   function automatic logic [127:0] sat(input int unsigned v, input int unsigned mx);
      return (v > mx) ? 128'(mx) : 128'(v);
   endfunction

   // Downstream ready generators
   initial begin
      m_tready        = 1'b1;
      m_eth_hdr_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (pay_mode)
            1:       m_tready = ~m_tready;
            2:       m_tready = ($urandom_range(0, 3) != 0);
            default: m_tready = 1'b1;
         endcase
         if (hdr_hold > 0) begin
            m_eth_hdr_ready = 1'b0;
            hdr_hold--;
         end else begin
            m_eth_hdr_ready = (hdr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
   end

   // Monitor: compares every output handshake against the scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (m_eth_hdr_valid && m_eth_hdr_ready) begin
               if (exp_hdr_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL hdr_unexpected: got dest %0h, expected no header", m_eth_dest_mac);
               end else begin
                  hdr_t h;
                  h = exp_hdr_q.pop_front();
                  chk("hdr_out", {m_eth_dest_mac, m_eth_src_mac, m_eth_type}, {h.dest, h.src, h.typ});
               end
            end
            if (m_tvalid && m_tready) begin
               if (exp_beat_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL beat_unexpected: got data %0h, expected no beat", m_tdata);
               end else begin
                  beat_t b;
                  b = exp_beat_q.pop_front();
                  chk("beat_out", {m_tdata, m_tkeep, m_tlast, m_tuser}, {b.data, 1'b1, b.last, b.user});
               end
            end
         end
      end
   end

   // Drive one frame; the reference decision is computed from the filter rules
   task automatic send_frame(input logic [47:0] dest, input logic [15:0] typ, input int len,
                             input bit prom, input bit exp_no_wait, input int abort_at);
      bit          pass;
      int          waited;
      bit          first;
      logic [47:0] src;
      hdr_t        h;
      beat_t       b;
      pass = (prom || dest == local_mac || dest == BCAST) && (typ == 16'h0800 || typ == 16'h0806);
      src  = {16'($urandom), 32'($urandom)};
      s_eth_hdr_valid = 1'b1;
      s_eth_dest_mac  = dest;
      s_eth_src_mac   = src;
      s_eth_type      = typ;
      promiscuous     = prom;
      waited = 0;
      forever begin
         @(negedge clk);
         if (s_eth_hdr_ready || waited > TIMEOUT) break;
         waited++;
      end
      if (waited > TIMEOUT) fail("hdr_accept");
      if (exp_no_wait) chk("hdr_b2b_wait", waited, 0);
      chk("hdr_prev_taken", exp_hdr_q.size(), 0);
      if (pass) begin
         h.dest = dest; h.src = src; h.typ = typ;
         exp_hdr_q.push_back(h);
      end
      @(posedge clk);
      #1;
      s_eth_hdr_valid = 1'b0;
      if (pass) mdl_pass++; else mdl_drop++;
      chk("hdr_valid_latency", m_eth_hdr_valid, pass);
      chk("busy_in_frame", busy, 1);
      chk("pass_count", pass_count, sat(mdl_pass, 65535));
      chk("drop_count", drop_count, sat(mdl_drop, 65535));
      chk("sat_pass_count", x_pass, sat(mdl_pass, 3));
      chk("sat_drop_count", x_drop, sat(mdl_drop, 3));
      for (int i = 0; i < len; i++) begin
         if (i > 0 && $urandom_range(0, 3) == 0) begin
            s_tvalid = 1'b0;
            @(posedge clk);
            #1;
         end
         if (abort_at >= 0 && i == abort_at) return;
         s_tvalid = 1'b1;
         s_tdata  = DW'($urandom);
         s_tkeep  = KW'($urandom);
         s_tlast  = (i == len - 1);
         s_tuser  = (i == len - 1) && ($urandom_range(0, 2) == 0);
         if (pass) begin
            b.data = s_tdata; b.last = s_tlast; b.user = s_tuser;
            exp_beat_q.push_back(b);
         end
         waited = 0;
         first  = 1'b1;
         forever begin
            @(negedge clk);
            if (!pass && first) chk("drop_tready", s_tready, 1);
            first = 1'b0;
            if (s_tready || waited > TIMEOUT) break;
            waited++;
         end
         if (waited > TIMEOUT) fail("beat_accept");
         @(posedge clk);
         #1;
         s_tvalid = 1'b0;
         s_tlast  = 1'b0;
      end
      chk("busy_after_last", busy, 0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_hdr_q.size() != 0 || exp_beat_q.size() != 0 || m_tvalid) && n < TIMEOUT) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= TIMEOUT) fail("drain");
   endtask

   // Global watchdog
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [47:0] d;
      logic [15:0] t;
      checks = 0; errors = 0;
      mdl_pass = 0; mdl_drop = 0;
      pay_mode = 0; hdr_mode = 0; hdr_hold = 0;
      rst = 1'b1;
      s_eth_hdr_valid = 1'b0; s_eth_dest_mac = '0; s_eth_src_mac = '0; s_eth_type = '0;
      s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
      local_mac = MAC_A; promiscuous = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hdr_valid", m_eth_hdr_valid, 0);
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_regs", {m_eth_dest_mac, m_eth_src_mac, m_eth_type, m_tdata}, 0);
      chk("rst_counts", {pass_count, drop_count}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tready", s_tready, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Unicast to local MAC, 46-byte payload
      send_frame(MAC_A, 16'h0800, 46, 1'b0, 1'b0, -1);
      drain();
      chk("pass_after_first", pass_count, 1);

      // Broadcast passes, foreign unicast drops
      send_frame(BCAST, 16'h0806, 8, 1'b0, 1'b0, -1);
      send_frame(MAC_B, 16'h0800, 10, 1'b0, 1'b0, -1);
      drain();
      chk("drop_after_foreign", drop_count, 1);

      // Disallowed EtherType drops; promiscuous accepts any MAC
      send_frame(MAC_A, 16'h86DD, 6, 1'b0, 1'b0, -1);
      send_frame(MAC_B, 16'h0800, 6, 1'b1, 1'b0, -1);
      drain();

      // Toggling payload ready, header held off for 20+ cycles
      pay_mode = 1;
      hdr_hold = 25;
      send_frame(MAC_A, 16'h0800, 4, 1'b0, 1'b0, -1);
      send_frame(BCAST, 16'h0800, 12, 1'b0, 1'b0, -1);
      drain();
      pay_mode = 0;

      // Back-to-back pass/drop/pass with header on the cycle after tlast
      send_frame(MAC_A, 16'h0806, 5, 1'b0, 1'b0, -1);
      send_frame(MAC_B, 16'h0806, 5, 1'b0, 1'b1, -1);
      send_frame(MAC_A, 16'h0800, 5, 1'b0, 1'b1, -1);
      drain();

      // Reset in the middle of a passing frame
      send_frame(MAC_A, 16'h0800, 10, 1'b0, 1'b0, 3);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_hdr_valid", m_eth_hdr_valid, 0);
      chk("midrst_tvalid", m_tvalid, 0);
      chk("midrst_regs", {m_eth_dest_mac, m_tdata, m_tlast}, 0);
      chk("midrst_counts", {pass_count, drop_count}, 0);
      chk("midrst_busy", busy, 0);
      exp_hdr_q.delete();
      exp_beat_q.delete();
      mdl_pass = 0; mdl_drop = 0;
      s_tvalid = 1'b0; s_tlast = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = 8'hA5;
      @(negedge clk);
      chk("stall_before_hdr", s_tready, 0);
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      send_frame(MAC_A, 16'h0800, 7, 1'b0, 1'b0, -1);
      send_frame(MAC_B, 16'h0800, 3, 1'b0, 1'b0, -1);
      drain();

      // Randomized traffic with random backpressure
      pay_mode = 2;
      hdr_mode = 1;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 7) == 0) local_mac = {16'($urandom), 32'($urandom)};
         case ($urandom_range(0, 3))
            0:       d = local_mac;
            1:       d = BCAST;
            2:       d = local_mac ^ (48'h1 << $urandom_range(0, 47));
            default: d = {16'($urandom), 32'($urandom)};
         endcase
         case ($urandom_range(0, 3))
            0:       t = 16'h0800;
            1:       t = 16'h0806;
            2:       t = 16'h86DD;
            default: t = 16'($urandom);
         endcase
         send_frame(d, t, $urandom_range(1, 20), ($urandom_range(0, 4) == 0), 1'b0, -1);
      end
      drain();
      chk("final_pass", pass_count, sat(mdl_pass, 65535));
      chk("final_drop", drop_count, sat(mdl_drop, 65535));
      chk("final_sat_pass", x_pass, sat(mdl_pass, 3));
      chk("final_sat_drop", x_drop, sat(mdl_drop, 3));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/eth_rx_filter.md
# eth_rx_filter

Frame filter that sits directly downstream of the Ethernet frame receiver. It consumes the parallel header fields and the payload AXI stream that the receiver produces. Each frame is either forwarded intact or discarded whole, based on destination MAC (unicast to local address, broadcast, or promiscuous) and EtherType (one of two allowed values). Downstream protocol stages (ARP/IP) see only frames addressed to this node.

## Interface
- DATA_WIDTH, 8, payload tdata width; multiple of 8
- KEEP_ENABLE, (DATA_WIDTH>8), propagate tkeep; when 0, output tkeep is all ones
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- ETH_TYPE_0, 16'h0800, first accepted EtherType
- ETH_TYPE_1, 16'h0806, second accepted EtherType
- CNT_WIDTH, 16, width of status counters

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- s_eth_hdr_valid / s_eth_hdr_ready  in / out  1  header handshake
- s_eth_dest_mac, s_eth_src_mac  in  48  header MACs, first octet in bits [47:40]
- s_eth_type  in  16  EtherType
- s_eth_payload_axis_tdata/tkeep/tvalid/tready/tlast/tuser  in (tready out)  DATA_WIDTH/KEEP_WIDTH/1/1/1/1  payload in
- m_eth_hdr_valid / m_eth_hdr_ready  out / in  1  forwarded header handshake
- m_eth_dest_mac, m_eth_src_mac, m_eth_type  out  48/48/16  forwarded header
- m_eth_payload_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out (tready in)  as input  payload out
- local_mac  in  48  station address; sampled at header accept
- promiscuous  in  1  bypass the MAC check; sampled at header accept
- busy  out  1  high in PASS or DROP
- pass_count, drop_count  out  CNT_WIDTH  saturating frame counters

## Operation
- FSM states: IDLE, PASS, DROP.
- IDLE:
  - s_eth_hdr_ready = !m_eth_hdr_valid.
  - Payload tready = 0.
- Header accept (valid && ready in IDLE):
  - mac_ok = promiscuous || dest==local_mac || dest==48'hFFFF_FFFF_FFFF.
  - type_ok = type==ETH_TYPE_0 || type==ETH_TYPE_1.
  - If both hold: latch the header into the m_ registers, set m_eth_hdr_valid, increment pass_count, go to PASS.
  - Otherwise: increment drop_count, go to DROP; m_eth_hdr_valid stays 0.
- PASS:
  - s_eth_hdr_ready = 0.
  - Payload passes through a one-deep output register, with s_eth_payload_axis_tready = !m_eth_payload_axis_tvalid || m_eth_payload_axis_tready.
  - tdata, tkeep, tlast and tuser are copied unchanged. tuser=1 frames are still forwarded and counted as passed.
  - Accepted beat with tlast=1: go to IDLE.
- DROP:
  - s_eth_hdr_ready = 0.
  - s_eth_payload_axis_tready = 1; beats are discarded.
  - Accepted beat with tlast=1: go to IDLE.
- m_eth_hdr_valid is held until m_eth_hdr_ready and is independent of payload progress. Payload may be forwarded before the header is consumed.
- The next header is not accepted until both of these hold: the FSM is in IDLE, and the prior header has been taken.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- busy = (state != IDLE).

## Timing
- Reset (async assert, sync release) sets:
  - state IDLE;
  - m_eth_hdr_valid = 0, m_eth_payload_axis_tvalid = 0;
  - all m_ data/header registers = 0;
  - pass_count = drop_count = 0, busy = 0.
- Reset mid-frame abandons the frame: the output beat is dropped and the FSM returns to IDLE. Payload arriving before the next header stalls (tready = 0).
- Header latency: accept on edge N; m_eth_hdr_valid = 1 after edge N (visible in cycle N+1).
- Header accepted on edge N (both paths):
  - Counter updates are visible from cycle N+1.
  - Payload tready first asserts in cycle N+1.
- Payload latency: one cycle in PASS. Full throughput (one beat per clock) when m_eth_payload_axis_tready is held high.
- Backpressure: if the output register is full and m_ready=0, s_tready=0 in the same cycle (combinational through the output register).
- A tlast beat and a downstream header handshake in the same cycle are both honoured. The next header can then be accepted in the following cycle.

## Test plan
- local_mac=02:00:00:00:00:01, header dest=02:00:00:00:00:01, type=0x0800, 46-byte payload, m ready=1 → header out 1 cycle after accept; 46 identical beats, tlast on beat 46; pass_count=1.
- dest=FF:FF:FF:FF:FF:FF, type=0x0806 → passed; dest=02:00:00:00:00:02, type=0x0800, promiscuous=0 → no m_eth_hdr_valid, no output beats, input tready=1 for all beats, drop_count=1.
- type=0x86DD to the local MAC → dropped; the same frame with promiscuous=1 and type=0x0800 → passed.
- Passing frame with m_eth_payload_axis_tready toggled 1/0 each cycle and m_eth_hdr_ready held low for 20 cycles → no beat lost or duplicated; second header stalls until the first header is taken.
- Back-to-back frames pass/drop/pass with a header presented on the cycle after tlast → header accepted one cycle later; counters pass=2, drop=1.
- Assert rst for 1 cycle mid-payload of a passing frame → all outputs 0 immediately; next frame processed normally. Force drop_count to 0xFFFF, drop one more frame → stays 0xFFFF.
